// File: rtl/risc_processor.sv
// risc_processor: multi-cycle 16-bit RISC core with a streamed-in program, data memory and an 8-entry register file
module risc_processor #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8,
  parameter int DW = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [23:0]        func,
  input  logic               new_func,
  input  logic               mem_enable,
  input  logic               start,
  output logic [IMEM_AW-1:0] pc,
  output logic               busy,
  output logic               halted,
  output logic [DW-1:0]      result
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_HALT = 3'd4;
  logic [2:0] state;
  logic [IMEM_AW-1:0] load_ptr, pc_inc;
  logic [23:0] ir;
  logic [DW-1:0] rf [8];
  logic [23:0] imem [2**IMEM_AW];
  logic [DW-1:0] dmem [2**DMEM_AW];
  logic [3:0] op;
  logic [2:0] rd, rs, rt;
  logic [7:0] imm;
  logic [DW-1:0] rd_v, rs_v, rt_v, imm_s, imm_z, addr_sum, wb_val;
  logic [DMEM_AW-1:0] daddr;
  logic is_wb, is_mem, wr_en, idle_like, unused_bits;
  assign op = ir[23:20];
  assign rd = ir[18:16];
  assign rs = ir[14:12];
  assign rt = ir[10:8];
  assign imm = ir[7:0];
  assign unused_bits = ^{ir[19], ir[15], ir[11]};
  assign rd_v = rf[rd];
  assign rs_v = rf[rs];
  assign rt_v = rf[rt];
  assign imm_s = {{(DW-8){imm[7]}}, imm};
  assign imm_z = {{(DW-8){1'b0}}, imm};
  assign addr_sum = rs_v + imm_z;
  assign daddr = addr_sum[DMEM_AW-1:0];
  assign pc_inc = pc + {{(IMEM_AW-1){1'b0}}, 1'b1};
  assign is_wb = op >= 4'h1 && op <= 4'h7;
  assign is_mem = op == 4'h8 || op == 4'h9;
  assign wr_en = (state == S_EXEC && is_wb) || (state == S_MEM && mem_enable && op == 4'h8);
  assign idle_like = state == S_IDLE || state == S_HALT;
  assign busy = state == S_FETCH || state == S_EXEC || state == S_MEM;
  assign halted = state == S_HALT;
  // write-back value: ALU/immediate result in EXEC, load data in MEM
  always_comb begin
    case (op)
      4'h1: wb_val = rs_v + rt_v;
      4'h2: wb_val = rs_v - rt_v;
      4'h3: wb_val = rs_v & rt_v;
      4'h4: wb_val = rs_v | rt_v;
      4'h5: wb_val = rs_v ^ rt_v;
      4'h6: wb_val = rs_v + imm_s;
      4'h7: wb_val = imm_z;
      default: wb_val = dmem[daddr];
    endcase
  end
  // program loading and stores; memories keep their contents across reset
  always_ff @(posedge clk) begin
    if (!reset && idle_like && !start && new_func) imem[load_ptr] <= func;
    if (!reset && state == S_MEM && mem_enable && op == 4'h9) dmem[daddr] <= rd_v;
  end
  // control FSM, program counter, instruction register and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pc <= '0;
      load_ptr <= '0;
      ir <= '0;
      result <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (wr_en) begin
        result <= wb_val;
        if (rd != 3'd0) rf[rd] <= wb_val;
      end
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc <= '0;
            state <= S_FETCH;
          end else if (new_func) load_ptr <= load_ptr + {{(IMEM_AW-1){1'b0}}, 1'b1};
        end
        S_FETCH: begin
          ir <= imem[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= op == 4'hF ? S_HALT : is_mem ? S_MEM : S_FETCH;
          pc <= op == 4'hB ? imm_z[IMEM_AW-1:0] :
                (op == 4'hA && rd_v == rs_v) ? pc_inc + imm_s[IMEM_AW-1:0] :
                (op == 4'hF || is_mem) ? pc : pc_inc;
        end
        S_MEM: begin
          if (mem_enable) begin
            pc <= pc_inc;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_risc_processor.sv
// tb_risc_processor: directed program vectors and multi-cycle corner sequences for risc_processor
module tb_risc_processor;
  logic clk = 1'b0;
  logic reset = 1'b1, new_func = 1'b0, mem_enable = 1'b1, start = 1'b0;
  logic [23:0] func = '0;
  logic [7:0] pc;
  logic busy, halted;
  logic [15:0] result;
  int total = 0, bad = 0;

  typedef struct packed {
    logic [0:5][23:0] prog;
    int n;
    logic [0:4][15:0] log;
    int nlog;
    int cyc;
    logic [7:0] pc;
  } vec_t;

  vec_t vecs[7];
  vec_t stall_prog;

  risc_processor dut (
    .clk(clk), .reset(reset), .func(func), .new_func(new_func), .mem_enable(mem_enable),
    .start(start), .pc(pc), .busy(busy), .halted(halted), .result(result)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [0:5][23:0] p, int n, logic [0:4][15:0] l, int nl, int c, logic [7:0] pcv);
    vec_t v;
    v.prog = p; v.n = n; v.log = l; v.nlog = nl; v.cyc = c; v.pc = pcv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic load_prog(input vec_t v);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      new_func = 1'b1;
      func = v.prog[i];
      @(negedge clk);
    end
    new_func = 1'b0;
  endtask

  task automatic run(input vec_t v, input string nm);
    logic [15:0] q[$];
    logic [15:0] prev;
    int cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    prev = result;
    while (!halted && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (result !== prev) q.push_back(result);
      prev = result;
    end
    chk({nm, "_halted"}, {31'd0, halted}, 32'd1);
    chk({nm, "_cycles"}, cyc, v.cyc);
    chk({nm, "_pc"}, {24'd0, pc}, {24'd0, v.pc});
    chk({nm, "_nwrites"}, q.size(), v.nlog);
    for (int i = 0; i < v.nlog && i < q.size(); i++)
      chk($sformatf("%s_result%0d", nm, i), {16'd0, q[i]}, {16'd0, v.log[i]});
  endtask

  initial begin
    bit ever_h;
    int cyc;
    vecs[0] = mk({24'h710005, 24'h720003, 24'h131200, 24'h241200, 24'hF00000, 24'h0}, 5,
                 {16'h0005, 16'h0003, 16'h0008, 16'h0002, 16'h0}, 4, 10, 8'd4);
    vecs[1] = mk({24'h710001, 24'h720001, 24'hA12001, 24'h730009, 24'h730007, 24'hF00000}, 6,
                 {16'h0001, 16'h0007, 16'h0, 16'h0, 16'h0}, 2, 10, 8'd5);
    vecs[2] = mk({24'h6100FF, 24'h121100, 24'h700033, 24'h130000, 24'hF00000, 24'h0}, 5,
                 {16'hFFFF, 16'hFFFE, 16'h0033, 16'h0000, 16'h0}, 4, 10, 8'd4);
    vecs[3] = mk({24'h71002A, 24'h910010, 24'h850010, 24'h165100, 24'hF00000, 24'h0}, 5,
                 {16'h002A, 16'h0054, 16'h0, 16'h0, 16'h0}, 2, 12, 8'd4);
    vecs[4] = mk({24'hB00005, 24'h770099, 24'h770099, 24'h770099, 24'h770099, 24'hF00000}, 6,
                 '0, 0, 4, 8'd5);
    vecs[5] = mk({24'h7100F0, 24'h72003C, 24'h331200, 24'h441200, 24'h551200, 24'hF00000}, 6,
                 {16'h00F0, 16'h003C, 16'h0030, 16'h00FC, 16'h00CC}, 5, 12, 8'd5);
    vecs[6] = mk({24'h710001, 24'h720002, 24'hA12001, 24'h730009, 24'hF00000, 24'h0}, 5,
                 {16'h0001, 16'h0002, 16'h0009, 16'h0, 16'h0}, 3, 10, 8'd4);
    stall_prog = mk({24'h71002A, 24'h910010, 24'h850010, 24'hF00000, 24'h0, 24'h0}, 4, '0, 0, 14, 8'd3);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);

    start = 1'b1; new_func = 1'b1; func = 24'hF00000;
    @(negedge clk);
    ever_h = 1'b0;
    for (int k = 0; k <= 520; k++) begin
      if (k == 0) chk("empty_busy", {31'd0, busy}, 32'd1);
      if (k inside {0, 1, 2, 3, 4, 5, 511, 512, 513}) chk($sformatf("empty_pc_k%0d", k), {24'd0, pc}, (k / 2) % 256);
      ever_h |= halted;
      start = (k == 6);
      new_func = (k == 6);
      @(negedge clk);
    end
    start = 1'b0; new_func = 1'b0;
    chk("empty_never_halted", {31'd0, ever_h}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      load_prog(vecs[i]);
      run(vecs[i], $sformatf("vec%0d", i));
    end

    load_prog(stall_prog);
    mem_enable = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) @(negedge clk);
    chk("stall_pc", {24'd0, pc}, 32'd1);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_result", {16'd0, result}, 32'h2A);
    mem_enable = 1'b1;
    cyc = 8;
    while (!halted && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_cycles", cyc, 14);
    chk("stall_end_pc", {24'd0, pc}, 32'd3);
    chk("stall_end_result", {16'd0, result}, 32'h2A);

    load_prog(vecs[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    chk("midrst_pre_pc", {24'd0, pc}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_pc", {24'd0, pc}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_halted", {31'd0, halted}, 32'd0);
    chk("midrst_result", {16'd0, result}, 32'd0);
    run(vecs[0], "rerun");
    run(vecs[0], "from_halt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/risc_processor.md
Name: risc_processor

Overview:
- Small multi-cycle 16-bit RISC core with internal 24-bit instruction memory, 16-bit data memory and an 8-entry register file.
- A program is streamed in word by word on func/new_func while idle. A start pulse runs it from address 0 until HALT.
- Top-level compute block. Debug outputs expose PC, status and last write-back value for verification.

Parameters:
- IMEM_AW, 8, instruction memory address width (256 x 24-bit words)
- DMEM_AW, 8, data memory address width (256 x 16-bit words)
- DW, 16, datapath / register width

Ports:
- clk  in  1  single system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- func  in  24  instruction word to load into instruction memory
- new_func  in  1  load strobe; writes func at load pointer
- mem_enable  in  1  data-memory access grant; low stalls LD/ST
- start  in  1  begin execution at PC 0
- pc  out  IMEM_AW  current program counter
- busy  out  1  high while executing (FETCH/EXEC/MEM)
- halted  out  1  high in HALT state
- result  out  DW  last value written to the register file

Behaviour:
- Instruction format: op[23:20], rd[18:16], rs[14:12], rt[10:8], imm8[7:0]. Bits 19, 15, 11 are ignored.
- Registers r0..r7 are DW bits wide. r0 reads 0, and writes to it are discarded.
- Opcodes:
  - 0 NOP
  - 1 ADD rd=rs+rt
  - 2 SUB rd=rs-rt
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 ADDI rd=rs+sext(imm8)
  - 7 LDI rd=zext(imm8)
  - 8 LD rd=dmem[rs+imm8]
  - 9 ST dmem[rs+imm8]=rd
  - A BEQ: if rd==rs then pc=pc+1+sext(imm8)
  - B JMP pc=imm8
  - F HALT
  - C/D/E execute as NOP.
- Arithmetic is modulo 2^DW with no flags. Data addresses use the low DMEM_AW bits of the sum. PC wraps from 255 to 0.
- FSM states: IDLE, FETCH, EXEC, MEM, HALT.
  - IDLE: start -> pc=0, go to FETCH. Otherwise, new_func -> imem[load_ptr]=func, load_ptr+1 (wraps). start has priority over new_func in the same cycle.
  - FETCH: ir=imem[pc], go to EXEC.
  - EXEC:
    - ALU ops, LDI and NOP: write back, pc+1, go to FETCH. Instruction latency is 2 cycles.
    - BEQ/JMP: update pc, go to FETCH.
    - LD/ST: go to MEM.
    - HALT: go to HALT, pc holds.
  - MEM: if mem_enable=1, perform the access (LD write-back), pc+1, go to FETCH. Latency is 3 cycles minimum. If mem_enable=0, stay in MEM with no side effects.
  - HALT: start -> pc=0, go to FETCH. new_func is accepted as in IDLE.
- new_func is ignored while busy.
- start while busy is ignored.
- Reset, including mid-instruction, takes one cycle and sets:
  - state=IDLE, pc=0, load_ptr=0, ir=0, r1..r7=0, result=0, busy=0, halted=0.
  - Memory contents are NOT cleared by reset.
- Instruction memory and data memory power up as all-zero. An unloaded program therefore runs NOPs continuously and wraps the PC.
- result updates only on register-file writes, including writes targeting r0, whose value is still shown on result.

Test Plan:
- reset=1 one cycle, then start pulse with empty memory -> busy=1, pc increments by 1 every 2 cycles, 0..255 then wraps to 0, halted stays 0.
- Load the program in IDLE, then start:
  - Program: LDI r1,5 (0x710005); LDI r2,3 (0x720003); ADD r3,r1,r2 (0x131200); SUB r4,r1,r2 (0x241200); HALT (0xF00000).
  - Response: result sequence 5,3,8,2; halted=1 with pc=4.
- LDI r1,0x2A; ST r1,[r0+0x10]; LD r5,[r0+0x10]; HALT with mem_enable held 0 for 4 cycles during the ST -> core stays in MEM, pc frozen at 1. After release, result=0x2A after the LD.
- BEQ/JMP:
  - Program: LDI r1,1; LDI r2,1; BEQ r1,r2,+1; LDI r3,9; LDI r3,7; HALT.
  - Response: skip taken, result final=7, no write of 9.
  - Program: JMP 0x05 at address 0 -> pc=5 on the next FETCH.
- Reset asserted mid-execution during EXEC of ADD -> next cycle pc=0, busy=0, registers 0. A start then reruns the still-loaded program with identical results.
- ADDI r1,r0,0xFF then ADD r2,r1,r1 -> r1=0xFFFF, result=0xFFFE (wrap). A write to r0 leaves subsequent reads of r0 at 0.
